// File: rtl/ram_pkg.sv
// ram_pkg: shared defaults, address-width helper and control state type for dual_port_ram.
package ram_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  typedef enum logic {ST_INIT, ST_READY} ram_state_e;
  function automatic int addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: LAT-stage read data/valid pipeline; each stage only loads on a valid word, so the output holds.
module ram_rd_pipe #(
  parameter int LAT = 1,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);
  logic [LAT-1:0] v;
  logic [DW-1:0] d [LAT];
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  assign out_valid = v[LAT-1];
  assign out_data = d[LAT-1];
endmodule

// File: rtl/dual_port_ram.sv
// dual_port_ram: 1W/1R RAM cleared by a sweep after reset, write-first bypass, RD_LAT 1..2.
// Optional even parity per word with fault injection when RAM_PARITY_EN is defined.
module dual_port_ram import ram_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
`ifdef RAM_PARITY_EN
  input  logic              wr_par_flip,
  output logic              rd_par_err,
`endif
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              init_busy
);
`ifdef RAM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  ram_state_e state;
  logic [ADDR_W-1:0] init_ptr, wa;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wr_word, rd_word, mem_word, pipe_in, pipe_out;
  logic ready, wr_ok, rd_ok, we;
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_INIT;
      init_ptr <= '0;
      init_busy <= 1'b1;
    end else if (state == ST_INIT) begin
      init_ptr <= (init_ptr == LAST) ? '0 : init_ptr + 1'b1;
      if (init_ptr == LAST) begin
        state <= ST_READY;
        init_busy <= 1'b0;
      end
    end
  assign ready = state == ST_READY;
  assign wr_ok = ready && wr_en && ({1'b0, wr_addr} < DEPTH_V);
  assign rd_ok = {1'b0, rd_addr} < DEPTH_V;
`ifdef RAM_PARITY_EN
  assign wr_word = {^wr_data ^ wr_par_flip, wr_data};
`else
  assign wr_word = wr_data;
`endif
  // The sweep owns the write port until the last address is cleared; all-zero words have even parity.
  assign we = !rst && (!ready || wr_ok);
  assign wa = ready ? wr_addr : init_ptr;
  always_ff @(posedge clk)
    if (we) mem[wa] <= ready ? wr_word : '0;
  assign mem_word = mem[rd_addr];
  assign rd_word = !rd_ok ? '0 : (wr_ok && wr_addr == rd_addr) ? wr_word : mem_word;
`ifdef RAM_PARITY_EN
  assign pipe_in = {^rd_word, rd_word[WIDTH-1:0]};
  assign rd_data = pipe_out[WIDTH-1:0];
  assign rd_par_err = pipe_out[WIDTH] & rd_valid;
`else
  assign pipe_in = rd_word;
  assign rd_data = pipe_out;
`endif
  ram_rd_pipe #(.LAT(RD_LAT), .DW(MW)) u_pipe (
    .clk(clk),
    .rst(rst),
    .in_valid(ready && rd_en),
    .in_data(pipe_in),
    .out_valid(rd_valid),
    .out_data(pipe_out)
  );
endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: scoreboard bench driving a DEPTH=16/RD_LAT=1 and a DEPTH=12/RD_LAT=2 instance in parallel.
module tb_dual_port_ram;
  typedef struct { logic [7:0] d; logic e; int c; } exp_t;
  logic clk = 0, rst = 1, wr_en = 0, rd_en = 0, wr_par_flip = 0;
  logic [3:0] wr_addr = 0, rd_addr = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] rd_data [2];
  logic rd_valid [2], init_busy [2];
`ifdef RAM_PARITY_EN
  logic pe [2];
`endif
  logic [7:0] m [2][16];
  logic pm [2][16];
  logic [7:0] last [2] = '{8'h00, 8'h00};
  int busy [2] = '{0, 0};
  exp_t q0[$], q1[$];
  int cyc = 0, nvec = 0, nbad = 0;
  bit started = 0;

  always #5 clk = ~clk;

  dual_port_ram #(.WIDTH(8), .DEPTH(16), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef RAM_PARITY_EN
    .wr_par_flip(wr_par_flip), .rd_par_err(pe[0]),
`endif
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .init_busy(init_busy[0]));

  dual_port_ram #(.WIDTH(8), .DEPTH(12), .RD_LAT(2)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef RAM_PARITY_EN
    .wr_par_flip(wr_par_flip), .rd_par_err(pe[1]),
`endif
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .init_busy(init_busy[1]));

  function automatic int dep(input int k);
    return k == 0 ? 16 : 12;
  endfunction
  function automatic int lat(input int k);
    return k == 0 ? 1 : 2;
  endfunction

  // Reference model: memory after the sweep is all zero; writes land before a same-edge read sees them.
  task automatic model(input int k);
    exp_t x;
    if (rst) begin
      busy[k] = dep(k);
      last[k] = 8'h00;
      if (k == 0) q0.delete(); else q1.delete();
    end else if (busy[k] > 0) begin
      busy[k]--;
      if (busy[k] == 0)
        for (int a = 0; a < 16; a++) begin m[k][a] = 8'h00; pm[k][a] = 1'b0; end
    end else begin
      if (wr_en && int'(wr_addr) < dep(k)) begin
        m[k][wr_addr] = wr_data;
        pm[k][wr_addr] = wr_par_flip;
      end
      if (rd_en) begin
        x.d = int'(rd_addr) < dep(k) ? m[k][rd_addr] : 8'h00;
        x.e = int'(rd_addr) < dep(k) && pm[k][rd_addr];
        x.c = cyc + lat(k) - 1;
        if (k == 0) q0.push_back(x); else q1.push_back(x);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) started = 1;
    model(0);
    model(1);
  end

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [7:0] d, input logic b, input logic p);
    exp_t x;
    int n;
    n = k == 0 ? q0.size() : q1.size();
    check("init_busy", k, {31'b0, b}, {31'b0, busy[k] > 0});
    if (v) begin
      if (n == 0) check("unexpected_valid", k, 1, 0);
      else begin
        x = k == 0 ? q0.pop_front() : q1.pop_front();
        check("rd_data", k, {24'b0, d}, {24'b0, x.d});
        check("rd_cycle", k, cyc, x.c);
`ifdef RAM_PARITY_EN
        check("rd_par_err", k, {31'b0, p}, {31'b0, x.e});
`endif
        last[k] = x.d;
      end
    end else begin
      check("rd_hold", k, {24'b0, d}, {24'b0, last[k]});
`ifdef RAM_PARITY_EN
      check("par_idle", k, {31'b0, p}, 0);
`endif
      if (n > 0) begin
        x = k == 0 ? q0[0] : q1[0];
        if (x.c < cyc) begin
          check("missing_valid", k, 0, 1);
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk)
    if (started) begin
`ifdef RAM_PARITY_EN
      mon(0, rd_valid[0], rd_data[0], init_busy[0], pe[0]);
      mon(1, rd_valid[1], rd_data[1], init_busy[1], pe[1]);
`else
      mon(0, rd_valid[0], rd_data[0], init_busy[0], 1'b0);
      mon(1, rd_valid[1], rd_data[1], init_busy[1], 1'b0);
`endif
    end

  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic re, input logic [3:0] ra, input logic fl);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra; wr_par_flip = fl;
  endtask

  task automatic rnd;
    drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_ready;
    int n = 0;
    while ((init_busy[0] || init_busy[1]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 0, n, n < 100 ? n : 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    wait_ready;
    idle(1);
    for (int a = 0; a < 16; a++) drive(0, 0, 0, 1, 4'(a), 0);
    idle(3);
    drive(1, 3, 8'hA5, 0, 0, 0);
    drive(0, 0, 0, 1, 3, 0);
    idle(3);
    drive(1, 7, 8'h3C, 1, 7, 0);
    idle(3);
    for (int a = 0; a < 4; a++) drive(1, 4'(a), 8'(8'h10 + a), 0, 0, 0);
    for (int a = 0; a < 4; a++) drive(0, 0, 0, 1, 4'(a), 0);
    idle(3);
    drive(1, 13, 8'hFF, 0, 0, 0);
    drive(0, 0, 0, 1, 13, 0);
    idle(3);
    drive(1, 5, 8'h01, 0, 0, 1);
    drive(0, 0, 0, 1, 5, 0);
    drive(1, 6, 8'h01, 0, 0, 0);
    drive(0, 0, 0, 1, 6, 0);
    idle(3);
    repeat (400) rnd;
    drive(0, 0, 0, 1, 2, 0);
    @(negedge clk);
    rst = 1; wr_en = 0; rd_en = 0;
    @(negedge clk);
    rst = 0;
    repeat (5) rnd;
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (6) rnd;
    idle(1);
    wait_ready;
    for (int a = 0; a < 16; a++) drive(0, 0, 0, 1, 4'(a), 0);
    repeat (100) rnd;
    idle(4);
    check("drain", 0, q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
- REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high.
- REQ-002 Parameter WIDTH, default 8: data word width in bits, legal range 1..64.
- REQ-003 Parameter DEPTH, default 16: number of words, legal range 2..1024; power of two not required.
- REQ-004 Parameter RD_LAT, default 1: read latency in clock cycles, legal values 1 or 2.
- REQ-005 Ports:
  - clk  in  1  rising-edge clock.
  - rst  in  1  synchronous active-high reset.
  - wr_en  in  1  write request.
  - wr_addr  in  ADDR_W  write address.
  - wr_data  in  WIDTH  write data.
  - rd_en  in  1  read request.
  - rd_addr  in  ADDR_W  read address.
  - rd_data  out  WIDTH  read data.
  - rd_valid  out  1  one-cycle pulse; rd_data is valid while it is high.
  - init_busy  out  1  high while the memory is being cleared.

Function
- REQ-006 Control FSM states:
  - ST_INIT: the clear sweep.
  - ST_READY: normal operation.
- REQ-007 FSM transitions:
  - ST_INIT -> ST_READY on the edge that writes address DEPTH-1.
  - Any state -> ST_INIT on rst.
- REQ-008 ST_INIT sweep: writes 0 to address init_ptr at each edge, init_ptr running 0..DEPTH-1; the sweep takes exactly DEPTH cycles after rst deasserts.
- REQ-009 init_busy SHALL be 1 in ST_INIT and 0 in ST_READY; it is registered.
- REQ-010 In ST_INIT, wr_en and rd_en SHALL be ignored: no write, no rd_valid.
- REQ-011 Write: in ST_READY, wr_en=1 at an edge SHALL store wr_data to mem[wr_addr] at that edge.
- REQ-012 Read: in ST_READY, rd_en=1 at edge N SHALL give rd_data and rd_valid=1 after edge N+RD_LAT-1, held for one cycle.
- REQ-013 Reads SHALL be fully pipelined: one read accepted per cycle, with no bubbles.
- REQ-014 rd_data SHALL hold its last value when rd_valid=0.
- REQ-015 Read/write collision, same address at the same edge: the read SHALL return the new wr_data (write-first bypass).
- REQ-016 Address at or above DEPTH:
  - A write SHALL be discarded.
  - A read SHALL return 0 with rd_valid=1.
- REQ-017 Simultaneous write and read to different addresses SHALL both complete independently.

Reset
- REQ-018 While rst=1, the block SHALL hold:
  - rd_data=0, rd_valid=0, init_busy=1.
  - init_ptr=0, state=ST_INIT.
  - All read-pipeline valid bits cleared.
- REQ-019 Reset mid-operation SHALL drop in-flight reads (no rd_valid is produced for them) and restart the clear sweep from address 0.
- REQ-020 Memory contents are not reset directly; they are cleared by the sweep.

Configuration
- REQ-021 Macro RAM_PARITY_EN defined: each word stores an extra even-parity bit.
- REQ-022 With RAM_PARITY_EN defined, the block SHALL add these ports:
  - wr_par_flip  in  1: inverts the stored parity bit of the current write (fault injection).
  - rd_par_err  out  1: high with rd_valid when the parity of the read word mismatches; reset value 0.
- REQ-023 With RAM_PARITY_EN defined, sweep-written words SHALL carry correct parity.
- REQ-024 Macro RAM_PARITY_EN undefined: no parity storage, and neither port exists.

Structure
- REQ-025 Package ram_pkg SHALL hold:
  - Default WIDTH and DEPTH values.
  - The ADDR_W derivation, $clog2(DEPTH) with a minimum of 1.
  - typedef enum ram_state_e {ST_INIT, ST_READY}.
- REQ-026 Sub-module ram_rd_pipe SHALL implement the RD_LAT-stage data/valid (and parity) pipeline.
- REQ-027 Storage SHALL be a single inferred array with one write port and one read port.

Verification
- REQ-028 Reset, then 16 cycles (DEPTH=16) -> init_busy falls on cycle 16; reads of addresses 0..15 return 0.
- REQ-029 Write 0xA5 to address 3, then read address 3:
  - RD_LAT=1 -> rd_data=0xA5 with rd_valid one cycle after the read edge.
  - RD_LAT=2 -> the same result one cycle later.
- REQ-030 Same-edge wr_en/rd_en to address 7 with wr_data 0x3C -> rd_data=0x3C.
- REQ-031 Back-to-back reads on 4 consecutive cycles of addresses 0..3 holding 0x10..0x13 -> 4 consecutive rd_valid pulses returning 0x10..0x13 in order.
- REQ-032 DEPTH=12, write 0xFF to address 13, then read address 13 -> rd_data=0; assert rst mid-sweep at init_ptr=5 -> the sweep restarts at 0 and init_busy stays high 12 more cycles.
- REQ-033 RAM_PARITY_EN: write 0x01 with wr_par_flip=1, then read -> rd_par_err=1 with rd_valid; a normal write of 0x01, then read -> rd_par_err=0.
